// File: rtl/riscv_cache_flush_if.sv
// AXI-Lite write-only bus (AW, W, B channels) between riscv_cache_flush and the interconnect.
interface riscv_cache_flush_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/riscv_cache_flush.sv
// Cache write-back engine: reads a range of cache entries and writes each one to memory as a
// single-beat AXI-Lite write. Define RISCV_CACHE_FLUSH_ABORT_ON_ERR_EN to stop on a bad bresp.
module riscv_cache_flush #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned INDEX_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [INDEX_WIDTH-1:0] i_first_idx,
    input  logic [INDEX_WIDTH:0]   i_count,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    output logic                   o_cache_read,
    output logic [ADDR_WIDTH-1:0]  o_cache_rd_addr,
    input  logic [DATA_WIDTH-1:0]  i_cache_data,
    riscv_cache_flush_if.master    axi,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error
);
    localparam int unsigned BytesPerEntry = DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StRd, StCap, StXfer, StResp, StDone} state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [INDEX_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   error_q, error_d;
    logic                   aw_hs, w_hs, bad_resp;

    assign aw_hs    = awvalid_q & axi.awready;
    assign w_hs     = wvalid_q & axi.wready;
    assign bad_resp = axi.bresp != 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            rem_q     <= '0;
            base_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            base_q    <= base_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        base_d       = base_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        error_d      = error_q;
        o_cache_read = 1'b0;
        axi.bready   = 1'b0;
        o_done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    idx_d   = i_first_idx;
                    rem_d   = i_count;
                    base_d  = i_base_addr;
                    error_d = 1'b0;
                    state_d = (i_count == '0) ? StDone : StRd;
                end
            end
            StRd: begin
                o_cache_read = 1'b1;
                state_d      = StCap;
            end
            StCap: begin
                // Cache data arrives one cycle after the read strobe.
                wdata_d   = i_cache_data;
                awaddr_d  = base_q + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(BytesPerEntry);
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = StXfer;
            end
            StXfer: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs) wvalid_d = 1'b0;
                if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) state_d = StResp;
            end
            StResp: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    if (bad_resp) error_d = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == 1) ? StDone : StRd;
`ifdef RISCV_CACHE_FLUSH_ABORT_ON_ERR_EN
                    if (bad_resp) state_d = StDone;
`endif
                end
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_cache_rd_addr = ADDR_WIDTH'(idx_q);
    assign axi.awvalid     = awvalid_q;
    assign axi.awaddr      = awaddr_q;
    assign axi.wvalid      = wvalid_q;
    assign axi.wdata       = wdata_q;
    assign axi.wstrb       = '1;
    assign o_busy          = (state_q != StIdle) && (state_q != StDone);
    assign o_error         = error_q;
endmodule

// File: tb/tb_riscv_cache_flush.sv
// Bench for riscv_cache_flush: directed and random flushes against a queue-based memory model.
`timescale 1ns/1ps
module tb_riscv_cache_flush;
    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned IW   = 8;
    localparam int unsigned NENT = 1 << IW;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic [IW-1:0] i_first_idx;
    logic [IW:0]   i_count;
    logic [AW-1:0] i_base_addr;
    logic          o_cache_read;
    logic [AW-1:0] o_cache_rd_addr;
    logic [DW-1:0] i_cache_data;
    logic          o_busy, o_done, o_error;

    riscv_cache_flush_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    riscv_cache_flush #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_start         (i_start),
        .i_first_idx     (i_first_idx),
        .i_count         (i_count),
        .i_base_addr     (i_base_addr),
        .o_cache_read    (o_cache_read),
        .o_cache_rd_addr (o_cache_rd_addr),
        .i_cache_data    (i_cache_data),
        .axi             (axi.master),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [NENT];
    logic [AW-1:0] aw_q [$];
    logic [DW-1:0] w_q [$];
    int            b_n, err_entry, aw_dly, w_dly, aw_cnt, w_cnt, done_cnt;
    bit            rand_dly;
    logic          rd_pend, aw_wait, w_wait;
    logic [IW-1:0] rd_idx;
    logic [AW-1:0] aw_hold;
    logic [DW-1:0] w_hold;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory-side responder: cache read port and AXI-Lite slave, updated at negedges.
    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
                rd_pend = 1'b0; aw_wait = 1'b0; w_wait = 1'b0; aw_cnt = 0; w_cnt = 0;
            end else begin
                i_cache_data = rd_pend ? mem[rd_idx] : {$urandom, $urandom};
                rd_pend      = o_cache_read;
                rd_idx       = o_cache_rd_addr[IW-1:0];
                if (aw_wait) begin
                    check("aw_valid_held", axi.awvalid, 1);
                    check("aw_addr_stable", axi.awaddr, aw_hold);
                end
                if (w_wait) begin
                    check("w_valid_held", axi.wvalid, 1);
                    check("w_data_stable", axi.wdata, w_hold);
                end
                if (axi.awvalid) begin
                    axi.awready = (aw_cnt >= aw_dly);
                    aw_cnt++;
                end else axi.awready = 1'b0;
                if (axi.wvalid) begin
                    axi.wready = (w_cnt >= w_dly);
                    w_cnt++;
                end else axi.wready = 1'b0;
                if (axi.awvalid && axi.awready) begin
                    aw_q.push_back(axi.awaddr);
                    aw_cnt = 0;
                    if (rand_dly) aw_dly = $urandom_range(0, 3);
                end
                if (axi.wvalid && axi.wready) begin
                    w_q.push_back(axi.wdata);
                    check("wstrb", axi.wstrb, 8'hFF);
                    w_cnt = 0;
                    if (rand_dly) w_dly = $urandom_range(0, 3);
                end
                aw_wait = axi.awvalid && !axi.awready;
                w_wait  = axi.wvalid && !axi.wready;
                aw_hold = axi.awaddr;
                w_hold  = axi.wdata;
                axi.bvalid = axi.bready && (aw_q.size() > b_n) && (w_q.size() > b_n);
                axi.bresp  = (b_n == err_entry) ? 2'b10 : 2'b00;
                if (axi.bvalid && axi.bready) b_n++;
                if (o_done) begin
                    done_cnt++;
                    check("busy_low_at_done", o_busy, 0);
                end
            end
        end
    end

    // One flush: builds the expected write list from the rules, runs it, compares.
    task automatic run_flush(input string tag, input logic [IW-1:0] first, input logic [IW:0] cnt,
                             input logic [AW-1:0] base, input int err_ent, input bit timed,
                             input bit poke);
        logic [AW-1:0] eaddr [$];
        logic [DW-1:0] edata [$];
        logic          eerr = 1'b0;
        int            idx, edges, d0;
        for (int k = 0; k < int'(cnt); k++) begin
            idx = (int'(first) + k) % NENT;
            eaddr.push_back(base + 64'(idx) * (DW / 8));
            edata.push_back(mem[idx]);
            if (k == err_ent) begin
                eerr = 1'b1;
`ifdef RISCV_CACHE_FLUSH_ABORT_ON_ERR_EN
                break;
`endif
            end
        end
        aw_q.delete(); w_q.delete(); b_n = 0; err_entry = err_ent; d0 = done_cnt;
        @(negedge clk);
        i_start = 1'b1; i_first_idx = first; i_count = cnt; i_base_addr = base;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                i_start = 1'b0; i_first_idx = IW'($urandom); i_count = (IW+1)'($urandom);
                i_base_addr = {$urandom, $urandom};
                check({tag, "_err_clr"}, o_error, 0);
            end
            if (poke && edges == 3) begin
                i_start = 1'b1; i_count = 9'd5;
            end
            if (poke && edges == 4) i_start = 1'b0;
        end while (!o_done && edges < 20000);
        check({tag, "_done"}, o_done, 1);
        if (timed) check({tag, "_latency"}, edges, 4 * int'(cnt) + 1);
        check({tag, "_error"}, o_error, eerr);
        check({tag, "_aw_count"}, aw_q.size(), eaddr.size());
        check({tag, "_w_count"}, w_q.size(), edata.size());
        for (int k = 0; k < eaddr.size() && k < aw_q.size() && k < w_q.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), aw_q[k], eaddr[k]);
            check($sformatf("%s_data%0d", tag, k), w_q[k], edata[k]);
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, o_done, 0);
        check({tag, "_idle"}, o_busy, 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        if (poke) begin
            repeat (8) @(posedge clk);
            #1;
            check({tag, "_poke_ignored_busy"}, o_busy, 0);
            check({tag, "_poke_no_writes"}, aw_q.size(), eaddr.size());
        end
    endtask

    initial begin
        logic [AW-1:0] base;
        int            cnt, ee, d0;
        for (int i = 0; i < NENT; i++) mem[i] = {$urandom, $urandom};
        reset = 1'b1; i_start = 1'b0; i_first_idx = '0; i_count = '0; i_base_addr = '0;
        i_cache_data = '0; axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.bresp = 2'b00; aw_dly = 0; w_dly = 0; rand_dly = 1'b0; err_entry = -1; b_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_cache_read", o_cache_read, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_awaddr", axi.awaddr, 0);
        check("rst_wdata", axi.wdata, 0);
        check("rst_wstrb", axi.wstrb, 8'hFF);
        @(negedge clk); reset = 1'b0;

        // Basic: three entries, zero-wait slave.
        mem[3] = 64'hA0A0_A0A0_0000_0000; mem[4] = 64'hA1A1_A1A1_1111_1111;
        mem[5] = 64'hA2A2_A2A2_2222_2222;
        run_flush("basic", 8'd3, 9'd3, 64'h1000, -1, 1'b1, 1'b0);
        check("basic_a0", aw_q[0], 64'h1018);
        check("basic_a2", aw_q[2], 64'h1028);
        check("basic_d1", w_q[1], 64'hA1A1_A1A1_1111_1111);

        // Index wrap through 0.
        run_flush("wrap", 8'hFF, 9'd2, 64'h0, -1, 1'b1, 1'b0);
        check("wrap_a0", aw_q[0], 64'h7F8);
        check("wrap_a1", aw_q[1], 64'h0);

        // Back-pressure on AW and W in both orders and together.
        aw_dly = 3; w_dly = 0;
        run_flush("bp_aw_late", 8'd20, 9'd2, 64'h8000, -1, 1'b0, 1'b0);
        aw_dly = 0; w_dly = 3;
        run_flush("bp_w_late", 8'd40, 9'd2, 64'h8000, -1, 1'b0, 1'b0);
        aw_dly = 1; w_dly = 1;
        run_flush("bp_same", 8'd60, 9'd2, 64'h8000, -1, 1'b0, 1'b0);
        aw_dly = 0; w_dly = 0;

        // Zero count and start-while-busy.
        run_flush("count0", 8'd7, 9'd0, 64'h4000, -1, 1'b1, 1'b0);
        run_flush("busy_start", 8'd9, 9'd2, 64'h4000, -1, 1'b1, 1'b1);

        // Error response on entry 2 of 4; sticky until next start.
        run_flush("slverr", 8'd100, 9'd4, 64'h2000, 1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", o_error, 1);
        run_flush("after_err", 8'd100, 9'd1, 64'h2000, -1, 1'b1, 1'b0);

        // Full cache with address wrap at the top of the address space.
        run_flush("full", IW'($urandom), 9'd256, 64'hFFFF_FFFF_FFFF_FC00, -1, 1'b1, 1'b0);

        // Random flushes with random per-beat back-pressure and errors.
        rand_dly = 1'b1;
        for (int r = 0; r < 8; r++) begin
            cnt  = $urandom_range(1, 12);
            base = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'hFFFF_FFFF_FFFF_FFC0;
            ee   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, cnt - 1) : -1;
            run_flush($sformatf("rnd%0d", r), IW'($urandom), (IW+1)'(cnt), base, ee, 1'b0, 1'b0);
        end
        rand_dly = 1'b0; aw_dly = 0; w_dly = 0;

        // Reset in the middle of a transfer.
        aw_dly = 6; aw_q.delete(); w_q.delete(); b_n = 0; err_entry = -1;
        @(negedge clk);
        i_start = 1'b1; i_first_idx = 8'd10; i_count = 9'd4; i_base_addr = 64'h3000;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int n = 0; n < 50 && !axi.awvalid; n++) begin
            @(posedge clk); #1;
        end
        check("mid_in_xfer", axi.awvalid, 1);
        d0 = done_cnt;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("mid_rst_awvalid", axi.awvalid, 0);
        check("mid_rst_wvalid", axi.wvalid, 0);
        check("mid_rst_bready", axi.bready, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_error", o_error, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0; aw_dly = 0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);
        run_flush("post_rst", 8'd30, 9'd3, 64'h5000, -1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
